// File: rtl/aes_cifra_iterativa_pkg.sv
// ---------------------------------------------------------------------------
// aes_cifra_iterativa_pkg
// Shared definitions for the iterative AES-128 encryption core:
//   - FSM state encoding (OCIOSO / RODANDO / PRONTO)
//   - S-box lookup, xtime, round-constant table and 128-bit byte reversal
// Byte convention: byte 0 of a 128-bit AES value is bits [127:120], i.e. the
// first two hex digits of the usual textual representation.
// ---------------------------------------------------------------------------
package aes_cifra_iterativa_pkg;

  typedef enum logic [1:0] {
    OCIOSO  = 2'd0,
    RODANDO = 2'd1,
    PRONTO  = 2'd2
  } fsm_estado_t;

  localparam int NUM_RODADAS = 10;

  // Forward S-box, entry 0 in the most significant byte.
  localparam logic [2047:0] SBOX_TABELA = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX_TABELA[2047 - 8*int'(b) -: 8];
  endfunction

  // Multiply by x in GF(2^8) modulo x^8+x^4+x^3+x+1.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Round constant for rounds 1..10; zero for any other index.
  function automatic logic [7:0] rcon_de(input logic [3:0] i);
    logic [7:0] r;
    case (i)
      4'd1:    r = 8'h01;
      4'd2:    r = 8'h02;
      4'd3:    r = 8'h04;
      4'd4:    r = 8'h08;
      4'd5:    r = 8'h10;
      4'd6:    r = 8'h20;
      4'd7:    r = 8'h40;
      4'd8:    r = 8'h80;
      4'd9:    r = 8'h1b;
      4'd10:   r = 8'h36;
      default: r = 8'h00;
    endcase
    return r;
  endfunction

  // Byte 0 <-> byte 15, byte 1 <-> byte 14, ...
  function automatic logic [127:0] inverte_bytes(input logic [127:0] x);
    logic [127:0] r;
    r = '0;
    for (int i = 0; i < 16; i++) r[8*i +: 8] = x[127-8*i -: 8];
    return r;
  endfunction

endpackage

// File: rtl/aes_cifra_iterativa_rodada.sv
// ---------------------------------------------------------------------------
// aes_cifra_iterativa_rodada
// One combinational AES-128 round plus one key-expansion step.
// Ports:
//   estado      in  128  state entering the round
//   chave_ant   in  128  previous round key
//   rcon        in  8    round constant for this round
//   ultima      in  1    final round: MixColumns is skipped
//   estado_novo out 128  state after AddRoundKey with chave_nova
//   chave_nova  out 128  round key for this round
// ---------------------------------------------------------------------------
module aes_cifra_iterativa_rodada
  import aes_cifra_iterativa_pkg::*;
(
  input  logic [127:0] estado,
  input  logic [127:0] chave_ant,
  input  logic [7:0]   rcon,
  input  logic         ultima,
  output logic [127:0] estado_novo,
  output logic [127:0] chave_nova
);

  logic [7:0]  sub_b  [16];
  logic [7:0]  desl_b [16];
  logic [7:0]  mix_b  [16];
  logic [31:0] w      [4];
  logic [31:0] temp;
  logic [31:0] nw0, nw1, nw2, nw3;

  genvar gi;

  // Byte i sits in column i/4, row i%4; ShiftRows rotates row r left by r.
  generate
    for (gi = 0; gi < 16; gi++) begin : g_bytes
      localparam int COL = gi / 4;
      localparam int ROW = gi % 4;
      assign sub_b[gi]  = sbox(estado[127-8*gi -: 8]);
      assign desl_b[gi] = sub_b[4*((COL+ROW)%4) + ROW];
      assign estado_novo[127-8*gi -: 8] =
        (ultima ? desl_b[gi] : mix_b[gi]) ^ chave_nova[127-8*gi -: 8];
    end

    for (gi = 0; gi < 4; gi++) begin : g_colunas
      logic [7:0] a0, a1, a2, a3;
      assign a0 = desl_b[4*gi];
      assign a1 = desl_b[4*gi+1];
      assign a2 = desl_b[4*gi+2];
      assign a3 = desl_b[4*gi+3];
      assign mix_b[4*gi]   = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
      assign mix_b[4*gi+1] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
      assign mix_b[4*gi+2] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
      assign mix_b[4*gi+3] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
      assign w[gi] = chave_ant[127-32*gi -: 32];
    end
  endgenerate

  // SubWord(RotWord(w3)) xor rcon, then the usual running xor across words.
  assign temp = {sbox(w[3][23:16]), sbox(w[3][15:8]), sbox(w[3][7:0]), sbox(w[3][31:24])}
              ^ {rcon, 24'h000000};
  assign nw0 = w[0] ^ temp;
  assign nw1 = w[1] ^ nw0;
  assign nw2 = w[2] ^ nw1;
  assign nw3 = w[3] ^ nw2;
  assign chave_nova = {nw0, nw1, nw2, nw3};

endmodule

// File: rtl/aes_cifra_iterativa.sv
// ---------------------------------------------------------------------------
// aes_cifra_iterativa
// Iterative AES-128 encryption core, ROUNDS_PER_CYCLE rounds per clock with
// on-the-fly key expansion. One job in flight at a time.
// Parameters:
//   ROUNDS_PER_CYCLE  1, 2, 5 or 10
//   BYTE_SWAP         1: reverse byte order of bloco/chave/cifrado at the ports
// Ports:
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   in_valid/in_ready     input handshake for bloco (plaintext) and chave (key)
//   out_valid/out_ready   output handshake for cifrado (ciphertext)
//   busy                  high while a job is running or waiting to be taken
// ---------------------------------------------------------------------------
module aes_cifra_iterativa
  import aes_cifra_iterativa_pkg::*;
#(
  parameter int ROUNDS_PER_CYCLE = 1,
  parameter bit BYTE_SWAP        = 1'b1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] bloco,
  input  logic [127:0] chave,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] cifrado,
  output logic         busy
);

  if (!(ROUNDS_PER_CYCLE inside {1, 2, 5, 10})) begin : g_param_invalido
    $error("aes_cifra_iterativa: ROUNDS_PER_CYCLE must be 1, 2, 5 or 10");
  end

  localparam logic [3:0] PASSO = 4'(ROUNDS_PER_CYCLE);
  localparam logic [3:0] ULTIMA_RODADA = 4'(NUM_RODADAS);

  fsm_estado_t  fsm_q, fsm_d;
  logic [127:0] estado_q, estado_d;
  logic [127:0] chave_q, chave_d;
  logic [3:0]   rodada_q, rodada_d;
  logic [127:0] cifrado_q, cifrado_d;

  logic [127:0] bloco_int, chave_int;
  logic [127:0] estado_final, chave_final;
  logic         aceita, termina;

  assign bloco_int = BYTE_SWAP ? inverte_bytes(bloco) : bloco;
  assign chave_int = BYTE_SWAP ? inverte_bytes(chave) : chave;

  // Round chain: block gi computes round rodada_q+gi+1.
  genvar gi;
  generate
    for (gi = 0; gi < ROUNDS_PER_CYCLE; gi++) begin : g_rodadas
      logic [127:0] est_ent, chave_ent, est_sai, chave_sai;
      logic [3:0]   numero;

      if (gi == 0) begin : g_primeira
        assign est_ent   = estado_q;
        assign chave_ent = chave_q;
      end else begin : g_seguinte
        assign est_ent   = g_rodadas[gi-1].est_sai;
        assign chave_ent = g_rodadas[gi-1].chave_sai;
      end

      assign numero = rodada_q + 4'(gi + 1);

      aes_cifra_iterativa_rodada u_rodada (
        .estado      (est_ent),
        .chave_ant   (chave_ent),
        .rcon        (rcon_de(numero)),
        .ultima      (numero == ULTIMA_RODADA),
        .estado_novo (est_sai),
        .chave_nova  (chave_sai)
      );
    end
  endgenerate

  assign estado_final = g_rodadas[ROUNDS_PER_CYCLE-1].est_sai;
  assign chave_final  = g_rodadas[ROUNDS_PER_CYCLE-1].chave_sai;

  assign aceita  = (fsm_q == OCIOSO) && in_valid;
  assign termina = (fsm_q == RODANDO) && ((rodada_q + PASSO) == ULTIMA_RODADA);

  // FSM: state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) fsm_q <= OCIOSO;
    else        fsm_q <= fsm_d;
  end

  // FSM: next state
  always_comb begin
    fsm_d = fsm_q;
    unique case (fsm_q)
      OCIOSO:  if (in_valid)  fsm_d = RODANDO;
      RODANDO: if (termina)   fsm_d = PRONTO;
      PRONTO:  if (out_ready) fsm_d = OCIOSO;
      default: fsm_d = OCIOSO;
    endcase
  end

  // FSM: outputs
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    unique case (fsm_q)
      OCIOSO:  in_ready = 1'b1;
      RODANDO: busy = 1'b1;
      PRONTO: begin
        out_valid = 1'b1;
        busy      = 1'b1;
      end
      default: ;
    endcase
  end

  // Datapath next values. The initial AddRoundKey is folded into the load.
  always_comb begin
    estado_d  = estado_q;
    chave_d   = chave_q;
    rodada_d  = rodada_q;
    cifrado_d = cifrado_q;
    if (aceita) begin
      estado_d = bloco_int ^ chave_int;
      chave_d  = chave_int;
      rodada_d = 4'd0;
    end else if (fsm_q == RODANDO) begin
      estado_d = estado_final;
      chave_d  = chave_final;
      rodada_d = rodada_q + PASSO;
      if (termina) begin
        cifrado_d = BYTE_SWAP ? inverte_bytes(estado_final) : estado_final;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      estado_q  <= '0;
      chave_q   <= '0;
      rodada_q  <= '0;
      cifrado_q <= '0;
    end else begin
      estado_q  <= estado_d;
      chave_q   <= chave_d;
      rodada_q  <= rodada_d;
      cifrado_q <= cifrado_d;
    end
  end

  assign cifrado = cifrado_q;

endmodule

// File: tb/tb_aes_cifra_iterativa.sv
// ---------------------------------------------------------------------------
// tb_aes_cifra_iterativa
// Four core instances: (R=1,swap=0) (R=10,swap=0) (R=2,swap=1) (R=5,swap=1).
// Known-answer table, randomized jobs against an in-bench AES model,
// backpressure, mid-run reset and busy-input sequences.
// ---------------------------------------------------------------------------
module tb_aes_cifra_iterativa;

  localparam int NDUT = 4;

  function automatic int rpc_of(input int k);
    case (k)
      0:       return 1;
      1:       return 10;
      2:       return 2;
      default: return 5;
    endcase
  endfunction

  function automatic bit bs_of(input int k);
    return k >= 2;
  endfunction

  logic            clk = 1'b0;
  logic            rst_n;
  logic [NDUT-1:0] in_valid, in_ready, out_valid, out_ready, busy;
  logic [127:0]    bloco   [NDUT];
  logic [127:0]    chave   [NDUT];
  logic [127:0]    cifrado [NDUT];

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int n_out [NDUT];

  logic [7:0] sbox_tab [256];

  typedef struct {
    logic [127:0] chave;
    logic [127:0] bloco;
    logic [127:0] esperado;
  } vetor_t;
  vetor_t tabela [3];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk)
    for (int k = 0; k < NDUT; k++)
      if (out_valid[k] && out_ready[k]) n_out[k] <= n_out[k] + 1;

  for (genvar gi = 0; gi < NDUT; gi++) begin : g_dut
    aes_cifra_iterativa #(
      .ROUNDS_PER_CYCLE (rpc_of(gi)),
      .BYTE_SWAP        (bs_of(gi))
    ) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid[gi]),
      .in_ready  (in_ready[gi]),
      .bloco     (bloco[gi]),
      .chave     (chave[gi]),
      .out_valid (out_valid[gi]),
      .out_ready (out_ready[gi]),
      .cifrado   (cifrado[gi]),
      .busy      (busy[gi])
    );
  end

  // ---------------- reference model (byte arrays, GF arithmetic) ----------
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // Multiplicative inverse as v^254, then the affine transform.
  function automatic logic [7:0] sbox_calc(input logic [7:0] v);
    logic [7:0] inv, s;
    inv = 8'h00;
    if (v != 8'h00) begin
      inv = 8'h01;
      for (int i = 0; i < 254; i++) inv = gmul(inv, v);
    end
    s = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
        ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    return s;
  endfunction

  function automatic logic [127:0] rev128(input logic [127:0] x);
    logic [127:0] r;
    r = '0;
    for (int i = 0; i < 16; i++) r[8*i +: 8] = x[127-8*i -: 8];
    return r;
  endfunction

  function automatic logic [127:0] model_aes(input logic [127:0] key, input logic [127:0] blk);
    logic [31:0]  w [44];
    logic [31:0]  t;
    logic [7:0]   rc;
    logic [7:0]   s [16];
    logic [7:0]   u [16];
    logic [127:0] res;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {sbox_tab[t[23:16]], sbox_tab[t[15:8]], sbox_tab[t[7:0]], sbox_tab[t[31:24]]}
            ^ {rc, 24'h000000};
        rc = gmul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int i = 0; i < 16; i++) s[i] = blk[127-8*i -: 8] ^ w[i/4][31-8*(i%4) -: 8];
    for (int r = 1; r <= 10; r++) begin
      for (int i = 0; i < 16; i++) u[i] = sbox_tab[s[i]];
      for (int c = 0; c < 4; c++)
        for (int row = 0; row < 4; row++) s[4*c+row] = u[4*((c+row)%4)+row];
      if (r < 10) begin
        for (int c = 0; c < 4; c++) begin
          for (int row = 0; row < 4; row++) u[row] = s[4*c+row];
          for (int row = 0; row < 4; row++)
            s[4*c+row] = gmul(u[row], 8'h02) ^ gmul(u[(row+1)%4], 8'h03)
                         ^ u[(row+2)%4] ^ u[(row+3)%4];
        end
      end
      for (int i = 0; i < 16; i++) s[i] = s[i] ^ w[4*r + i/4][31-8*(i%4) -: 8];
    end
    res = '0;
    for (int i = 0; i < 16; i++) res[127-8*i -: 8] = s[i];
    return res;
  endfunction

  // ---------------- checking and driving tasks ----------------------------
  task automatic check(input string nome, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", nome, got, exp);
    end else begin
      $display("ok   %s: %h", nome, got);
    end
  endtask

  task automatic submit(input int k, input logic [127:0] key_std, input logic [127:0] blk_std,
                        output int hs, output bit ok);
    int espera;
    espera = 0;
    ok = 1'b1;
    hs = 0;
    @(negedge clk);
    chave[k]    = bs_of(k) ? rev128(key_std) : key_std;
    bloco[k]    = bs_of(k) ? rev128(blk_std) : blk_std;
    in_valid[k] = 1'b1;
    while (!in_ready[k]) begin
      if (espera == 100) begin
        n_checks++;
        n_fail++;
        $display("FAIL submit_timeout dut%0d: in_ready=%b, required 1", k, in_ready[k]);
        in_valid[k] = 1'b0;
        ok = 1'b0;
        return;
      end
      espera++;
      @(negedge clk);
    end
    hs = cyc + 1;
    @(posedge clk);
    #1;
    // Data changes after the handshake must not affect the job.
    in_valid[k] = 1'b0;
    bloco[k] = {$urandom, $urandom, $urandom, $urandom};
    chave[k] = {$urandom, $urandom, $urandom, $urandom};
  endtask

  task automatic wait_result(input int k, input bit garble, output logic [127:0] got_std,
                             output int lat, output bit ok);
    lat = 0;
    ok = 1'b1;
    got_std = '0;
    while (1) begin
      @(posedge clk);
      #1;
      lat++;
      if (out_valid[k]) break;
      if (lat == 100) begin
        n_checks++;
        n_fail++;
        $display("FAIL result_timeout dut%0d: out_valid=%b, required 1", k, out_valid[k]);
        in_valid[k] = 1'b0;
        ok = 1'b0;
        return;
      end
      if (garble) begin
        in_valid[k] = 1'($urandom);
        bloco[k] = {$urandom, $urandom, $urandom, $urandom};
        chave[k] = {$urandom, $urandom, $urandom, $urandom};
      end
    end
    if (garble) in_valid[k] = 1'b0;
    got_std = bs_of(k) ? rev128(cifrado[k]) : cifrado[k];
  endtask

  // ---------------- test sequence ----------------------------------------
  initial begin
    logic [127:0] got, exp, c0;
    logic [127:0] rk, rb;
    int hs, prev_hs, lat, n0, n_busy;
    bit ok, ok2, estavel;

    for (int v = 0; v < 256; v++) sbox_tab[v] = sbox_calc(8'(v));

    tabela[0] = '{128'h000102030405060708090a0b0c0d0e0f,
                  128'h00112233445566778899aabbccddeeff,
                  128'h69c4e0d86a7b0430d8cdb78070b4c55a};
    tabela[1] = '{128'h2b7e151628aed2a6abf7158809cf4f3c,
                  128'h3243f6a8885a308d313198a2e0370734,
                  128'h3925841d02dc09fbdc118597196a0b32};
    tabela[2] = '{128'h0, 128'h0, 128'h66e94bd4ef8a2c3b884cfa59ca342b2e};

    for (int v = 0; v < 3; v++)
      check($sformatf("model_vec%0d", v), model_aes(tabela[v].chave, tabela[v].bloco),
            tabela[v].esperado);

    rst_n = 1'b0;
    in_valid = '0;
    out_ready = '1;
    for (int k = 0; k < NDUT; k++) begin
      bloco[k] = '0;
      chave[k] = '0;
    end
    repeat (3) @(negedge clk);
    for (int k = 0; k < NDUT; k++) begin
      check($sformatf("reset_ctrl dut%0d {in_ready,out_valid,busy}", k),
            128'({in_ready[k], out_valid[k], busy[k]}), 128'(3'b100));
      check($sformatf("reset_cifrado dut%0d", k), cifrado[k], 128'h0);
    end
    rst_n = 1'b1;

    // Known-answer vectors, back-to-back per instance.
    for (int k = 0; k < NDUT; k++) begin
      n0 = n_out[k];
      prev_hs = 0;
      for (int v = 0; v < 3; v++) begin
        submit(k, tabela[v].chave, tabela[v].bloco, hs, ok);
        if (!ok) continue;
        wait_result(k, 1'b0, got, lat, ok2);
        if (!ok2) continue;
        check($sformatf("kat dut%0d vec%0d cifrado", k, v), got, tabela[v].esperado);
        check($sformatf("kat dut%0d vec%0d latency", k, v), 128'(lat), 128'(10 / rpc_of(k)));
        if (v > 0)
          check($sformatf("kat dut%0d vec%0d interval", k, v), 128'(hs - prev_hs),
                128'(10 / rpc_of(k) + 2));
        prev_hs = hs;
      end
      @(negedge clk);
      #1;
      check($sformatf("kat dut%0d output count", k), 128'(n_out[k] - n0), 128'd3);
    end

    // Randomized jobs against the model.
    for (int k = 0; k < NDUT; k++) begin
      for (int j = 0; j < 6; j++) begin
        rk = {$urandom, $urandom, $urandom, $urandom};
        rb = {$urandom, $urandom, $urandom, $urandom};
        exp = model_aes(rk, rb);
        submit(k, rk, rb, hs, ok);
        if (!ok) continue;
        wait_result(k, 1'b0, got, lat, ok2);
        if (!ok2) continue;
        check($sformatf("rand dut%0d job%0d key=%h blk=%h", k, j, rk, rb), got, exp);
      end
    end

    // Backpressure on the R=2, swapped instance.
    @(negedge clk);
    out_ready[2] = 1'b0;
    submit(2, tabela[1].chave, tabela[1].bloco, hs, ok);
    if (ok) begin
      wait_result(2, 1'b0, got, lat, ok2);
      if (ok2) begin
        c0 = cifrado[2];
        check("stall dut2 cifrado", c0, rev128(tabela[1].esperado));
        estavel = 1'b1;
        for (int i = 0; i < 20; i++) begin
          @(posedge clk);
          #1;
          if (cifrado[2] !== c0 || out_valid[2] !== 1'b1 || in_ready[2] !== 1'b0 ||
              busy[2] !== 1'b1) estavel = 1'b0;
        end
        check("stall dut2 held 20 cycles", 128'(estavel), 128'd1);
        out_ready[2] = 1'b1;
        @(posedge clk);
        #1;
        check("stall dut2 release {out_valid,in_ready}",
              128'({out_valid[2], in_ready[2]}), 128'(2'b01));
      end
    end
    out_ready[2] = 1'b1;

    // in_valid toggled with garbage while busy on the R=1 instance.
    n0 = n_out[0];
    submit(0, tabela[0].chave, tabela[0].bloco, hs, ok);
    if (ok) begin
      wait_result(0, 1'b1, got, lat, ok2);
      if (ok2) begin
        check("busy_input dut0 cifrado", got, tabela[0].esperado);
        n_busy = 0;
        for (int i = 0; i < 12; i++) begin
          @(posedge clk);
          #1;
          if (busy[0]) n_busy++;
        end
        check("busy_input dut0 no extra job", 128'(n_busy), 128'd0);
        check("busy_input dut0 output count", 128'(n_out[0] - n0), 128'd1);
      end
    end

    // Reset at rodada=5 on the R=1 instance.
    submit(0, tabela[0].chave, tabela[0].bloco, hs, ok);
    if (ok) begin
      repeat (5) @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      check("midreset dut0 {in_ready,out_valid,busy}",
            128'({in_ready[0], out_valid[0], busy[0]}), 128'(3'b100));
      check("midreset dut0 cifrado", cifrado[0], 128'h0);
      @(negedge clk);
      rst_n = 1'b1;
      n0 = n_out[0];
      repeat (15) @(posedge clk);
      #1;
      check("midreset dut0 no output after reset", 128'(n_out[0] - n0), 128'd0);
      submit(0, tabela[0].chave, tabela[0].bloco, hs, ok);
      if (ok) begin
        wait_result(0, 1'b0, got, lat, ok2);
        if (ok2) check("midreset dut0 next job", got, tabela[0].esperado);
      end
    end

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
